dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the word-addressed data memory: 256 x 32-bit words, word index addr[9:2], combinational read gated by mem_read, write on posedge clk when mem_write.
- Port 0: core load/store unit. Port 1: debug/loader port.
- Grants one requester at a time, drives the memory strobes, and returns registered read data.
- Performs read-modify-write for partial (byte-enable) stores, so the memory stays word-only.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_addr  in  ADDR_W  port 0 byte address
- req0_we  in  1  port 0 write (1) / read (0)
- req0_be  in  4  port 0 byte enables (writes only)
- req0_wdata  in  DATA_W  port 0 write data
- rsp0_valid  out  1  port 0 response pulse
- rsp0_rdata  out  DATA_W  port 0 read data
- req1_valid, req1_ready, req1_addr, req1_we, req1_be, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  memory address, always word-aligned
- mem_write_data  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_read_data  in  DATA_W  memory combinational read data

Behaviour:
- Reset: synchronous, active-high, checked every posedge; dominates all other conditions.
  - FSM goes to IDLE.
  - All outputs go to 0: ready, rsp_valid, rsp_rdata, mem_addr, mem_write_data, mem_read, mem_write.
  - Reset mid-transaction drops it: no response issued, and mem_write is 0 from the reset cycle on.
- FSM states: IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP.
- IDLE:
  - If any reqN_valid is set, grant one port and assert reqN_ready combinationally for that port only, in the same cycle.
  - Latch addr, we, be and wdata; record the granted port.
  - Next state:
    - read -> ACCESS
    - write with be=4'hF -> ACCESS
    - write with be=4'h0 -> RESP (no memory access)
    - any other write -> RMW_READ
- Ready rules:
  - reqN_ready is asserted only in IDLE.
  - A requester must hold valid and payload stable until ready.
  - At most one transaction is outstanding; no pipelining.
- ACCESS:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Read: mem_read=1; capture mem_read_data into the response register.
  - Full write: mem_write=1, mem_write_data=wdata; response data = 0.
  - Next state: RESP.
- RMW_READ:
  - mem_read=1.
  - Build merged word: byte i = wdata byte i if be[i], else mem_read_data byte i.
  - Next state: RMW_WRITE.
- RMW_WRITE: mem_write=1 with the merged word; next state RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle on the granted port only.
  - rspN_rdata holds the value until the next response on that port.
  - Next state: IDLE. No new grant in this cycle; the earliest new accept is the following cycle.
- Latency from the accept cycle T:
  - rsp_valid at T+2 for reads and full writes.
  - rsp_valid at T+3 for partial writes.
  - rsp_valid at T+1 for be=0 writes.
- Strobes:
  - mem_read and mem_write are never both 1.
  - Both are 0 in IDLE and RESP.
  - mem_addr and mem_write_data hold their last value when idle.
- Address rules:
  - Address bits [1:0] are ignored; there is no misalignment fault.
  - Addresses beyond the memory depth alias through the memory's own indexing.
- Arbitration (default): fixed priority, port 0 wins when both are valid.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register is updated on every grant; reset value 1, so port 0 wins the first contention.
  - When both ports are valid, the port that is not last_grant wins.
  - With a single valid port, that port is granted regardless of last_grant.
- Undefined: fixed priority to port 0, and the last_grant register is absent.

Test Plan:
- Read: memory word 3 = 32'hDEADBEEF; port 0 reads addr 32'h0000000C -> req0_ready at T, mem_read=1 with mem_addr=32'h0C at T+1, rsp0_valid at T+2 with rsp0_rdata=32'hDEADBEEF, rsp1_valid stays 0.
- Full write then read: port 1 writes 32'h12345678 to addr 32'h10 with be=4'hF -> mem_write pulses once at T+1; a subsequent port 1 read returns 32'h12345678.
- Partial write: word at 32'h14 = 32'hAABBCCDD; port 0 writes wdata=32'h11223344 with be=4'b0101 -> mem_read at T+1, mem_write at T+2 with data 32'hAA22CC44, rsp0_valid at T+3.
- Contention: both ports valid every cycle for 4 transactions.
  - Macro undefined: grant order 0,0,0,0.
  - Macro defined: grant order 0,1,0,1.
  - In both cases each response appears only on the granted port.
- Reset mid-operation: assert reset during RMW_READ of a partial write -> no mem_write that cycle or after, no rsp_valid, target word unchanged; next cycle the FSM is in IDLE with all outputs 0 and the next request is accepted.
- Zero enables and alignment: a write with be=4'h0 -> rsp_valid at T+1 and no mem strobe; a read of addr 32'h0000000F -> mem_addr=32'h0000000C.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of a word-addressed
// data memory (256 x 32-bit, combinational read, write on posedge clk).
// Partial (byte-enable) stores are done as read-modify-write so that the
// memory only ever sees whole-word accesses.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req0_* / rsp0_*       port 0 (core load/store unit) request/response
//   req1_* / rsp1_*       port 1 (debug/loader) request/response
//   mem_addr              word-aligned memory address (holds when idle)
//   mem_write_data        memory write data (holds when idle)
//   mem_read, mem_write   memory strobes, never both high
//   mem_read_data         combinational memory read data
//
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between the ports on contention
//   undefined -> fixed priority, port 0 wins
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic                req0_we,
    input  logic [DATA_W/8-1:0] req0_be,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_rdata,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic                req1_we,
    input  logic [DATA_W/8-1:0] req1_be,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_read_data
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_READ,
        RMW_WRITE,
        RESP
    } state_t;

    state_t              state;
    logic                port_q;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;

    logic                grant0;
    logic                grant1;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_we;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   merged;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Port that won the most recent grant; resets to 1 so port 0 wins
    // the first contention.
    logic last_grant;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && !grant0;
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && !reset && grant0;
    assign req1_ready = (state == IDLE) && !reset && grant1;

    // Strobes are gated by reset so a write in flight never reaches the
    // memory on the reset cycle itself.
    assign mem_read  = mem_read_q  && !reset;
    assign mem_write = mem_write_q && !reset;

    always_comb begin
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_be    = grant1 ? req1_be    : req0_be;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_read_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp0_rdata     <= '0;
            rsp1_rdata     <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        port_q   <= grant1;
                        we_q     <= sel_we;
                        be_q     <= sel_be;
                        wdata_q  <= sel_wdata;
                        mem_addr <= sel_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_grant <= grant1;
`endif
                        if (!sel_we) begin
                            mem_read_q <= 1'b1;
                            state      <= ACCESS;
                        end else if (sel_be == '1) begin
                            mem_write_q    <= 1'b1;
                            mem_write_data <= sel_wdata;
                            state          <= ACCESS;
                        end else if (sel_be == '0) begin
                            // Nothing to store: answer straight away.
                            if (grant1) begin
                                rsp1_valid <= 1'b1;
                                rsp1_rdata <= '0;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_rdata <= '0;
                            end
                            state <= RESP;
                        end else begin
                            mem_read_q <= 1'b1;
                            state      <= RMW_READ;
                        end
                    end
                end
                ACCESS: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (port_q) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= we_q ? '0 : mem_read_data;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= we_q ? '0 : mem_read_data;
                    end
                    state <= RESP;
                end
                RMW_READ: begin
                    mem_read_q     <= 1'b0;
                    mem_write_q    <= 1'b1;
                    mem_write_data <= merged;
                    state          <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    mem_write_q <= 1'b0;
                    if (port_q) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= '0;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= '0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
